mmu_result_deskew_accumulator: RTL and testbench

Downstream stage of the Matrix_Multiply_Unit systolic array. It captures the diagonally skewed Result lanes and deskews them into aligned column vectors. Each vector is written or accumulated into an addressable accumulator buffer. A registered read port hands finished tiles to the next stage (activation/writeback).

---
 rtl/mmu_result_deskew_accumulator_pkg.sv | 20 ++
 rtl/mmu_result_deskew_accumulator_lane_delay.sv | 34 +++
 rtl/mmu_result_deskew_accumulator.sv | 168 ++++++++++++++++
 tb/tb_mmu_result_deskew_accumulator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_result_deskew_accumulator_pkg.sv
// Shared definitions for the MMU result deskew / accumulator slice.
//   - default array edge, lane width and buffer depth
//   - acc_vec_t: one aligned column vector (SA_LENGTH_DEF signed lanes)
//   - state_t:   tile-capture FSM encoding, also exported on the debug port
package mmu_pkg;

  localparam int SA_LENGTH_DEF      = 3;
  localparam int ACC_DATA_WIDTH_DEF = 32;
  localparam int ACC_DEPTH_DEF      = 16;

  // Lane y lives in bits [y*W +: W].
  typedef logic signed [SA_LENGTH_DEF-1:0][ACC_DATA_WIDTH_DEF-1:0] acc_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } state_t;

endpackage

// File: rtl/mmu_result_deskew_accumulator_lane_delay.sv
// Depth-N register delay line for one Result lane.
// Ports:
//   i_clk  - clock, rising edge
//   i_arst - asynchronous active-high clear of all stages
//   i_srst - synchronous active-high clear of all stages
//   i_d    - lane input
//   o_q    - lane input delayed by exactly N cycles
module mmu_lane_delay #(
  parameter int N = 1,
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_srst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < N; i++) r_stage[i] <= '0;
    end else if (i_srst) begin
      for (int i = 0; i < N; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/mmu_result_deskew_accumulator.sv
// Deskews the diagonally skewed Result lanes of the systolic array into
// aligned column vectors and writes or accumulates them into a buffer.
// Ports:
//   CLK, ASYNC_RST (async, active high), SYNC_RST (sync clear, buffer kept)
//   START      - pulse on offset 0 of a tile (lane 0 carries element 0)
//   BASE_ADDR  - buffer address of vector 0, sampled with START
//   ACCUMULATE - sampled with START: 1 = add into entry, 0 = overwrite
//   Result     - skewed lanes; lane y valid at offsets y..y+SA_LENGTH-1
//   RD_EN/RD_ADDR -> RD_DATA/RD_VALID one cycle later (registered)
//   BUSY       - high from offset 1 to offset 2*SA_LENGTH-1
//   DONE       - one-cycle pulse at offset 2*SA_LENGTH
//   o_dbg_state - current FSM state
// Tile protocol: START is only accepted in IDLE (including the DONE cycle,
// which allows back-to-back tiles); a START while BUSY is dropped.
module mmu_result_deskew_accumulator
  import mmu_pkg::*;
#(
  parameter int SA_LENGTH              = SA_LENGTH_DEF,
  parameter int ACCUMULATOR_DATA_WIDTH = ACC_DATA_WIDTH_DEF,
  parameter int ACC_DEPTH              = ACC_DEPTH_DEF,
  parameter int ADDR_WIDTH             = $clog2(ACC_DEPTH)
) (
  input  logic                                                CLK,
  input  logic                                                ASYNC_RST,
  input  logic                                                SYNC_RST,
  input  logic                                                START,
  input  logic [ADDR_WIDTH-1:0]                               BASE_ADDR,
  input  logic                                                ACCUMULATE,
  input  logic signed [SA_LENGTH-1:0][ACCUMULATOR_DATA_WIDTH-1:0] Result,
  input  logic                                                RD_EN,
  input  logic [ADDR_WIDTH-1:0]                               RD_ADDR,
  output logic signed [SA_LENGTH-1:0][ACCUMULATOR_DATA_WIDTH-1:0] RD_DATA,
  output logic                                                RD_VALID,
  output logic                                                BUSY,
  output logic                                                DONE,
  output state_t                                              o_dbg_state
);

  localparam int CNT_W = (SA_LENGTH > 1) ? $clog2(2*SA_LENGTH) : 1;

  typedef logic [SA_LENGTH-1:0][ACCUMULATOR_DATA_WIDTH-1:0] vec_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;       // tile offset while not IDLE
  logic [ADDR_WIDTH-1:0] r_wr_addr;   // address of the vector written this cycle
  logic                  r_acc;
  logic                  r_done;
  logic                  w_start_ok;
  logic                  w_wr_en;
  logic                  w_last;
  vec_t                  w_aligned;
  vec_t                  w_wr_vec;
  vec_t                  r_mem [ACC_DEPTH];
  vec_t                  r_rd_data;
  logic                  r_rd_valid;

  // Lane y enters at offset k+y and must leave at offset SA_LENGTH+k, so it
  // needs SA_LENGTH-y stages; all lanes then line up for vector k.
  for (genvar y = 0; y < SA_LENGTH; y++) begin : g_lane
    mmu_lane_delay #(
      .N (SA_LENGTH - y),
      .W (ACCUMULATOR_DATA_WIDTH)
    ) u_dly (
      .i_clk  (CLK),
      .i_arst (ASYNC_RST),
      .i_srst (SYNC_RST),
      .i_d    (Result[y]),
      .o_q    (w_aligned[y])
    );
  end

  // Next-state logic. The delay lines run freely; only WRITE-state cycles
  // (offsets SA_LENGTH..2*SA_LENGTH-1) commit, which is exactly when the
  // aligned outputs hold in-window lane values.
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_wr_en      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_start_ok   = 1'b1;
          w_next_state = (SA_LENGTH == 1) ? WRITE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (r_cnt == CNT_W'(SA_LENGTH - 1)) w_next_state = WRITE;
      end
      WRITE: begin
        w_wr_en = 1'b1;
        if (r_cnt == CNT_W'(2*SA_LENGTH - 1)) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_acc     <= 1'b0;
      r_done    <= 1'b0;
    end else if (SYNC_RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_acc     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last;
      if (w_start_ok) begin
        r_cnt     <= CNT_W'(1);
        r_wr_addr <= BASE_ADDR;
        r_acc     <= ACCUMULATE;
      end else begin
        if (w_last)                r_cnt <= '0;
        else if (r_state != IDLE)  r_cnt <= r_cnt + 1'b1;
        // Natural wrap at ACC_DEPTH since ADDR_WIDTH covers it exactly.
        if (w_wr_en) r_wr_addr <= r_wr_addr + 1'b1;
      end
    end
  end

  // Per-lane two's-complement add, wrapping silently.
  always_comb begin
    w_wr_vec = w_aligned;
    if (r_acc) begin
      for (int y = 0; y < SA_LENGTH; y++) begin
        w_wr_vec[y] = r_mem[r_wr_addr][y] + w_aligned[y];
      end
    end
  end

  // Buffer has no reset. A sync reset in a write cycle suppresses the write
  // so that a reset mid-tile never commits another vector.
  always_ff @(posedge CLK) begin
    if (w_wr_en && !SYNC_RST) r_mem[r_wr_addr] <= w_wr_vec;
  end

  // Registered read; same-cycle write to the same entry is not forwarded,
  // so the pre-write contents are returned.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (SYNC_RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= RD_EN;
      if (RD_EN) r_rd_data <= r_mem[RD_ADDR];
    end
  end

  assign RD_DATA     = r_rd_data;
  assign RD_VALID    = r_rd_valid;
  assign BUSY        = (r_state != IDLE);
  assign DONE        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmu_result_deskew_accumulator.sv
// Bench for mmu_result_deskew_accumulator (SA_LENGTH=3, ACC_DEPTH=16).
module tb_mmu_result_deskew_accumulator;
  import mmu_pkg::*;

  localparam int SA = 3;
  localparam int VW = SA * 32;
  localparam int PAT_LIN  = 0;
  localparam int PAT_RAND = 1;
  localparam int PAT_OVF  = 2;
  localparam int PAT_ONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             ASYNC_RST, SYNC_RST, START, ACCUMULATE, RD_EN;
  logic [3:0]       BASE_ADDR, RD_ADDR;
  logic [2:0][31:0] Result;
  logic [2:0][31:0] RD_DATA;
  logic             RD_VALID, BUSY, DONE;
  state_t           dbg_state;

  mmu_result_deskew_accumulator dut (
    .CLK         (clk),
    .ASYNC_RST   (ASYNC_RST),
    .SYNC_RST    (SYNC_RST),
    .START       (START),
    .BASE_ADDR   (BASE_ADDR),
    .ACCUMULATE  (ACCUMULATE),
    .Result      (Result),
    .RD_EN       (RD_EN),
    .RD_ADDR     (RD_ADDR),
    .RD_DATA     (RD_DATA),
    .RD_VALID    (RD_VALID),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [VW-1:0]    exp_q[$];          // expected read data, in request order
  logic [2:0][31:0] exp_mem [16];      // buffer contents as the rules dictate
  logic [31:0]      m_cap [SA][SA];    // m_cap[k][y] = element y of vector k
  bit               m_active;
  int               m_off;
  logic [3:0]       m_base;
  bit               m_acc;
  bit               m_done;
  bit               m_rv;
  logic [VW-1:0]    m_rd;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [VW-1:0] vec3(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [31:0] lane_val(input int pat, input int y, input int k);
    case (pat)
      PAT_LIN: return 32'(10*y + k);
      PAT_OVF: return (y == 0 && k == 0) ? 32'h7FFF_FFFF : 32'h0;
      PAT_ONE: return (y == 0 && k == 0) ? 32'h1 : 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    m_active = 0;
    m_off    = 0;
    m_done   = 0;
    m_rv     = 0;
    m_rd     = '0;
    exp_q.delete();
  endtask

  // Effect of one clock cycle with the given inputs, from the tile rules:
  // element y of vector k is lane y at offset k+y; vector k is committed at
  // the end of offset SA+k to base+k; DONE follows the last commit.
  task automatic model_update(input logic st, input logic [3:0] base, input logic acc,
                              input logic [2:0][31:0] res, input logic re,
                              input logic [3:0] ra, input logic sr);
    int         k;
    logic [3:0] a;
    if (sr) begin
      model_clear();
      return;
    end
    m_rv = re;
    if (re) exp_q.push_back(exp_mem[ra]);
    m_done = 0;
    if (st && !(m_active && m_off >= 1)) begin
      m_active = 1;
      m_off    = 0;
      m_base   = base;
      m_acc    = acc;
    end
    if (m_active) begin
      for (int y = 0; y < SA; y++) begin
        k = m_off - y;
        if (k >= 0 && k < SA) m_cap[k][y] = res[y];
      end
      if (m_off >= SA) begin
        k = m_off - SA;
        a = m_base + 4'(k);
        for (int y = 0; y < SA; y++)
          exp_mem[a][y] = m_acc ? exp_mem[a][y] + m_cap[k][y] : m_cap[k][y];
      end
      m_off++;
      if (m_off == 2*SA) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", VW'(BUSY), VW'(m_active && m_off >= 1));
    check("done", VW'(DONE), VW'(m_done));
    check("rd_valid", VW'(RD_VALID), VW'(m_rv));
    if (m_rv && exp_q.size() > 0) m_rd = exp_q.pop_front();
    check("rd_data", RD_DATA, m_rd);
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; drives one cycle and checks the result.
  task automatic step(input logic st, input logic [3:0] base, input logic acc,
                      input logic [2:0][31:0] res, input logic re,
                      input logic [3:0] ra, input logic sr);
    START = st; BASE_ADDR = base; ACCUMULATE = acc; Result = res;
    RD_EN = re; RD_ADDR = ra; SYNC_RST = sr;
    model_update(st, base, acc, res, re, ra, sr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [2:0][31:0] rand_vec();
    logic [2:0][31:0] v;
    for (int y = 0; y < SA; y++) v[y] = $urandom;
    return v;
  endfunction

  task automatic arst_mid();
    START = 0; RD_EN = 0; SYNC_RST = 0;
    #2 ASYNC_RST = 1;
    #1;
    model_clear();
    check("arst_busy", VW'(BUSY), '0);
    check("arst_done", VW'(DONE), '0);
    check("arst_rd_valid", VW'(RD_VALID), '0);
    check("arst_rd_data", RD_DATA, '0);
    @(posedge clk);
    #1;
    ASYNC_RST = 0;
    check_outputs();
  endtask

  // One tile from offset 0; optional ignored START (xs_off), read (rd_off)
  // and asynchronous abort (abort_off). Non-aborted tiles end on the DONE cycle.
  task automatic run_tile(input logic [3:0] base, input logic acc, input int pat,
                          input int xs_off, input int rd_off, input logic [3:0] rd_a,
                          input int abort_off);
    logic [2:0][31:0] res;
    int k;
    for (int off = 0; off < 2*SA; off++) begin
      if (off == abort_off) begin
        arst_mid();
        return;
      end
      for (int y = 0; y < SA; y++) begin
        k = off - y;
        res[y] = (k >= 0 && k < SA) ? lane_val(pat, y, k) : 32'hFFFF_FFFF;
      end
      step(off == 0 || off == xs_off, (off == 0) ? base : base + 4'd7,
           (off == 0) ? acc : ~acc, res, off == rd_off, rd_a, 1'b0);
    end
    check("tile_done", VW'(DONE), VW'(1));
    check("tile_busy_end", VW'(BUSY), VW'(0));
  endtask

  task automatic read_const(input string tag, input logic [3:0] addr, input logic [VW-1:0] exp);
    step(1'b0, 4'd0, 1'b0, rand_vec(), 1'b1, addr, 1'b0);
    check(tag, RD_DATA, exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [VW-1:0] save9, save10;
    ASYNC_RST = 1; SYNC_RST = 0; START = 0; BASE_ADDR = 0; ACCUMULATE = 0;
    Result = '0; RD_EN = 0; RD_ADDR = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", VW'(BUSY), '0);
    check("rst_done", VW'(DONE), '0);
    check("rst_rd_valid", VW'(RD_VALID), '0);
    check("rst_rd_data", RD_DATA, '0);
    ASYNC_RST = 0;
    @(posedge clk);
    #1;
    check_outputs();

    // Give every buffer entry a known value (base 15 also exercises wrap).
    for (int b = 0; b < 16; b += 3) run_tile(4'(b), 1'b0, PAT_RAND, -1, -1, 4'd0, -1);

    // Overwrite deskew.
    run_tile(4'd4, 1'b0, PAT_LIN, -1, -1, 4'd0, -1);
    read_const("ow_a4", 4'd4, vec3(0, 10, 20));
    read_const("ow_a5", 4'd5, vec3(1, 11, 21));
    read_const("ow_a6", 4'd6, vec3(2, 12, 22));

    // Accumulate back-to-back, read collision on vector-1 write, ignored START.
    run_tile(4'd4, 1'b0, PAT_LIN, -1, -1, 4'd0, -1);
    run_tile(4'd4, 1'b1, PAT_LIN, 3, 4, 4'd5, -1);
    read_const("acc_a4", 4'd4, vec3(0, 20, 40));
    read_const("acc_a5", 4'd5, vec3(2, 22, 42));
    read_const("acc_a6", 4'd6, vec3(4, 24, 44));

    // Wrap and signed overflow.
    run_tile(4'd15, 1'b0, PAT_OVF, -1, -1, 4'd0, -1);
    run_tile(4'd15, 1'b1, PAT_ONE, -1, -1, 4'd0, -1);
    read_const("ovf_a15", 4'd15, vec3(32'h8000_0000, 0, 0));
    read_const("wrap_a0", 4'd0, vec3(0, 0, 0));
    read_const("wrap_a1", 4'd1, vec3(0, 0, 0));

    // Mid-tile asynchronous reset at offset 4, then a normal tile.
    save9  = exp_mem[9];
    save10 = exp_mem[10];
    run_tile(4'd8, 1'b0, PAT_LIN, -1, -1, 4'd0, 4);
    step(1'b0, 4'd0, 1'b0, rand_vec(), 1'b0, 4'd0, 1'b0);
    read_const("abort_a8", 4'd8, vec3(0, 10, 20));
    read_const("abort_a9", 4'd9, save9);
    read_const("abort_a10", 4'd10, save10);
    run_tile(4'd8, 1'b0, PAT_RAND, -1, -1, 4'd0, -1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           rand_vec(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
